// File: rtl/counter_updown_param_pkg.sv
// Shared constants for the parametrised up/down counter: direction encodings
// on up_dn and the wrap/saturate mode values accepted by SATURATE.
package counter_updown_param_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;
  localparam int   MODE_WRAP = 0;
  localparam int   MODE_SAT  = 1;

endpackage

// File: rtl/counter_prescale.sv
// Enable prescaler: counts en cycles 0..PRESCALE-1 and flags the cycle on
// which the owning counter may step. Used only under COUNTER_PRESCALE_EN.
module counter_prescale #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic step
);

  // A divide-by-1 still needs one flop bit so the port list stays uniform.
  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;

  assign step = en && (pre_q == LAST);

  always_comb begin
    pre_d = pre_q;
    if (clr)       pre_d = '0;
    else if (step) pre_d = '0;
    else if (en)   pre_d = pre_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) pre_q <= '0;
    else     pre_q <= pre_d;
  end

endmodule

// File: rtl/counter_updown_param.sv
// Parametrised synchronous up/down counter with load, wrap/saturate, tc pulse
// and sticky overflow. Define COUNTER_PRESCALE_EN to divide en by PRESCALE.
module counter_updown_param
  import counter_updown_param_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MODULO   = 256,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  if (WIDTH < 1 || MODULO < 2 || MODULO > (1 << WIDTH) || PRESCALE < 1)
  begin : g_bad_params
    $error("counter_updown_param: illegal WIDTH/MODULO/PRESCALE combination");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);
  localparam logic             SAT     = (SATURATE == MODE_SAT);

  logic             step;
  logic             limit;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

`ifdef COUNTER_PRESCALE_EN
  counter_prescale #(
    .PRESCALE (PRESCALE)
  ) u_prescale (
    .clk  (clk),
    .rst  (rst),
    .clr  (load),
    .en   (en),
    .step (step)
  );
`else
  assign step = en;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    count_d = count_q;
    limit   = 1'b0;
    if (load) begin
      count_d = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;
    end else if (step) begin
      if (up_dn == DIR_UP) begin
        if (count_q == MAX_VAL) begin
          limit   = 1'b1;
          count_d = SAT ? MAX_VAL : '0;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          limit   = 1'b1;
          count_d = SAT ? '0 : MAX_VAL;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
    tc_d  = limit;
    // A limit event on the same edge as clr_ovf keeps the flag set.
    ovf_d = limit | (ovf_q & ~clr_ovf);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_counter_updown_param.sv
// Scoreboard bench: three counter configurations share one stimulus stream and
// are checked against an arithmetic reference model of the counting rules.
module tb_counter_updown_param;

  localparam int PRE = 4;
  localparam int NDUT = 3;

  typedef struct packed {
    logic [2:0] cnt;
    logic       tc;
    logic       ovf;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       load = 1'b0;
  logic [2:0] load_val = '0;
  logic       clr_ovf = 1'b0;

  logic [2:0] count0, count1, count2;
  logic       tc0, tc1, tc2, ovf0, ovf1, ovf2;

  int n_checks = 0;
  int n_fail   = 0;

  obs_t q0[$];
  obs_t q1[$];
  obs_t q2[$];

  // Reference configurations: {MODULO, SATURATE}
  int mod_a[NDUT] = '{8, 8, 5};
  int sat_a[NDUT] = '{0, 1, 0};
  int m_cnt[NDUT] = '{0, 0, 0};
  int m_ovf[NDUT] = '{0, 0, 0};
  int m_tc[NDUT]  = '{0, 0, 0};
  int m_pre[NDUT] = '{0, 0, 0};

  always #5 clk = ~clk;

  counter_updown_param #(.WIDTH(3), .MODULO(8), .SATURATE(0), .PRESCALE(PRE)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .count(count0), .tc(tc0), .ovf(ovf0));

  counter_updown_param #(.WIDTH(3), .MODULO(8), .SATURATE(1), .PRESCALE(PRE)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .count(count1), .tc(tc1), .ovf(ovf1));

  counter_updown_param #(.WIDTH(3), .MODULO(5), .SATURATE(0), .PRESCALE(PRE)) dut_mod5 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .count(count2), .tc(tc2), .ovf(ovf2));

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: next observable state of configuration i for the inputs
  // presented this cycle.
  task automatic model(input int i);
    int nxt;
    bit do_step;
    if (rst) begin
      m_cnt[i] = 0; m_tc[i] = 0; m_ovf[i] = 0; m_pre[i] = 0;
      return;
    end
    m_tc[i] = 0;
    if (clr_ovf) m_ovf[i] = 0;
    if (load) begin
      m_cnt[i] = (int'(load_val) >= mod_a[i]) ? mod_a[i] - 1 : int'(load_val);
      m_pre[i] = 0;
      return;
    end
`ifdef COUNTER_PRESCALE_EN
    do_step = 1'b0;
    if (en) begin
      if (m_pre[i] == PRE - 1) begin
        do_step = 1'b1;
        m_pre[i] = 0;
      end else begin
        m_pre[i]++;
      end
    end
`else
    do_step = en;
`endif
    if (do_step) begin
      nxt = up_dn ? m_cnt[i] + 1 : m_cnt[i] - 1;
      if (nxt == mod_a[i] || nxt < 0) begin
        m_tc[i]  = 1;
        m_ovf[i] = 1;
        if (sat_a[i] == 0) m_cnt[i] = (nxt + mod_a[i]) % mod_a[i];
      end else begin
        m_cnt[i] = nxt;
      end
    end
  endtask

  function automatic obs_t pack_obs(input int i);
    obs_t o;
    o.cnt = 3'(m_cnt[i]);
    o.tc  = m_tc[i][0];
    o.ovf = m_ovf[i][0];
    return o;
  endfunction

  task automatic cyc(input logic r, input logic e, input logic u, input logic l,
                     input logic [2:0] lv, input logic c);
    @(negedge clk);
    rst = r; en = e; up_dn = u; load = l; load_val = lv; clr_ovf = c;
    for (int i = 0; i < NDUT; i++) model(i);
    q0.push_back(pack_obs(0));
    q1.push_back(pack_obs(1));
    q2.push_back(pack_obs(2));
  endtask

  // Monitor: the counter presents a fresh output after every edge.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("wrap.count", int'(count0), int'(e.cnt));
        check("wrap.tc",    int'(tc0),    int'(e.tc));
        check("wrap.ovf",   int'(ovf0),   int'(e.ovf));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("sat.count", int'(count1), int'(e.cnt));
        check("sat.tc",    int'(tc1),    int'(e.tc));
        check("sat.ovf",   int'(ovf1),   int'(e.ovf));
      end
      if (q2.size() > 0) begin
        e = q2.pop_front();
        check("mod5.count", int'(count2), int'(e.cnt));
        check("mod5.tc",    int'(tc2),    int'(e.tc));
        check("mod5.ovf",   int'(ovf2),   int'(e.ovf));
      end
    end
  end

  initial begin
    int steps;
`ifdef COUNTER_PRESCALE_EN
    steps = PRE;
`else
    steps = 1;
`endif
    repeat (10) cyc(1, 0, 1, 0, 3'd0, 0);
    repeat (9 * steps) cyc(0, 1, 1, 0, 3'd0, 0);
    cyc(0, 0, 1, 1, 3'd2, 0);
    repeat (3 * steps) cyc(0, 1, 0, 0, 3'd0, 0);
    cyc(0, 0, 1, 1, 3'd6, 0);
    repeat (3 * steps) cyc(0, 1, 1, 0, 3'd0, 0);
    cyc(0, 1, 1, 1, 3'd6, 0);                   // load beats en
    repeat (2 * steps) cyc(0, 1, 1, 0, 3'd0, 0);
    cyc(0, 0, 1, 1, 3'd7, 0);
    repeat (steps) cyc(0, 1, 1, 0, 3'd0, 1);    // clear on a limit edge
    cyc(0, 0, 1, 0, 3'd0, 1);
    cyc(0, 0, 1, 1, 3'd5, 0);
    cyc(1, 1, 1, 0, 3'd0, 0);                   // reset mid-count
    repeat (6) cyc(0, 1, 1, 0, 3'd0, 0);
    repeat (2) cyc(0, 0, 1, 0, 3'd0, 0);        // en gap delays the next step
    repeat (6) cyc(0, 1, 1, 0, 3'd0, 0);
    repeat (600) cyc($urandom_range(49) == 0, $urandom_range(3) != 0, 1'($urandom),
                     $urandom_range(7) == 0, 3'($urandom), $urandom_range(7) == 0);
    for (int k = 0; k < 4 && q0.size() > 0; k++) @(posedge clk);
    #2;
    check("scoreboard.drained", q0.size() + q1.size() + q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
